// File: rtl/tt_um_sameerhegde_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : tt_um_sameerhegde_serial_adder
// Purpose  : Byte-serial handshaked adder on the TinyTapeout user pinout.
//            Two NBYTES-wide operands arrive LSB-first on ui_in under a
//            valid/ready handshake, are summed one byte per clock with a
//            rippling carry, and the sum is streamed back LSB-first on uo_out
//            under a second valid/ready handshake. The carry-out of the full
//            addition is presented on a flag for the whole output phase.
// Ports    :
//   clk      in   1  clock, all state changes on the rising edge
//   rst_n    in   1  synchronous reset, active low
//   ena      in   1  design enable; 0 freezes every register
//   ui_in    in   8  operand byte
//   uio_in   in   8  [0] in_valid, [1] out_ready, [7:2] unused
//   uo_out   out  8  current result byte (registered)
//   uio_out  out  8  [2] in_ready, [3] out_valid, [4] carry, others 0
//   uio_oe   out  8  constant 8'b0001_1100
// Params   : NBYTES  operand/result width in bytes, legal range 1..4
// Revision : 1.0  initial release
// ============================================================================
module tt_um_sameerhegde_serial_adder #(
  parameter int NBYTES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int             CNT_W    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBYTES - 1);

  localparam logic [1:0] ST_LOAD_A = 2'd0;
  localparam logic [1:0] ST_LOAD_B = 2'd1;
  localparam logic [1:0] ST_ADD    = 2'd2;
  localparam logic [1:0] ST_OUT    = 2'd3;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [1:0]       r_state;
  logic [1:0]       w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_a   [NBYTES];
  logic [7:0]       r_b   [NBYTES];
  logic [7:0]       r_sum [NBYTES];
  logic             r_c;          // running carry between byte additions
  logic             r_carry;      // carry flag presented to the outside
  logic             r_out_valid;
  logic [7:0]       r_uo_out;

  // --------------------------------------------------------------------------
  // Handshake decode
  // --------------------------------------------------------------------------
  logic w_in_valid;
  logic w_out_ready;
  logic w_in_ready;
  logic w_in_fire;
  logic w_out_fire;
  logic w_last;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [8:0]       w_add;
  logic             w_unused;

  assign w_in_valid  = uio_in[0];
  assign w_out_ready = uio_in[1];
  assign w_unused    = &{1'b0, uio_in[7:2]};

  assign w_last    = (r_cnt == LAST_CNT);
  assign w_cnt_inc = r_cnt + CNT_W'(1);

  // Only the LOAD states advertise ready; a transfer also needs ena so a
  // frozen design never silently swallows a byte.
  assign w_in_fire  = w_in_valid & w_in_ready & ena;
  assign w_out_fire = r_out_valid & w_out_ready & ena & (r_state == ST_OUT);

  // One byte of the ripple addition, indexed by the shared byte counter.
  assign w_add = {1'b0, r_a[r_cnt]} + {1'b0, r_b[r_cnt]} + {8'd0, r_c};

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_LOAD_A;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    if (ena) begin
      case (r_state)
        ST_LOAD_A: if (w_in_fire && w_last)  w_state_next = ST_LOAD_B;
        ST_LOAD_B: if (w_in_fire && w_last)  w_state_next = ST_ADD;
        ST_ADD:    if (w_last)               w_state_next = ST_OUT;
        ST_OUT:    if (w_out_fire && w_last) w_state_next = ST_LOAD_A;
        default:                             w_state_next = ST_LOAD_A;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // FSM: output decode
  // --------------------------------------------------------------------------
  // in_ready is gated by rst_n so it drops in the same cycle reset asserts,
  // not one edge later.
  always_comb begin
    w_in_ready = 1'b0;
    if ((r_state == ST_LOAD_A) || (r_state == ST_LOAD_B)) begin
      w_in_ready = rst_n;
    end
  end

  assign uo_out  = r_uo_out;
  assign uio_out = {3'b000, r_carry, r_out_valid, w_in_ready, 2'b00};
  assign uio_oe  = 8'b0001_1100;

  // --------------------------------------------------------------------------
  // Datapath: operand capture, serial addition, result streaming
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_c         <= 1'b0;
      r_carry     <= 1'b0;
      r_out_valid <= 1'b0;
      r_uo_out    <= 8'd0;
      for (int i = 0; i < NBYTES; i++) begin
        r_a[i]   <= 8'd0;
        r_b[i]   <= 8'd0;
        r_sum[i] <= 8'd0;
      end
    end else if (ena) begin
      case (r_state)
        ST_LOAD_A: begin
          if (w_in_fire) begin
            r_a[r_cnt] <= ui_in;
            r_cnt      <= w_last ? '0 : w_cnt_inc;
          end
        end

        ST_LOAD_B: begin
          if (w_in_fire) begin
            r_b[r_cnt] <= ui_in;
            r_cnt      <= w_last ? '0 : w_cnt_inc;
            if (w_last) begin
              r_c <= 1'b0;
            end
          end
        end

        ST_ADD: begin
          r_sum[r_cnt] <= w_add[7:0];
          r_c          <= w_add[8];
          if (w_last) begin
            r_cnt       <= '0;
            r_out_valid <= 1'b1;
            r_carry     <= w_add[8];
            // With a single-byte operand the low result byte is the one being
            // computed on this very edge, so bypass the sum register.
            r_uo_out    <= (r_cnt == '0) ? w_add[7:0] : r_sum[0];
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end

        ST_OUT: begin
          if (w_out_fire) begin
            if (w_last) begin
              r_cnt       <= '0;
              r_out_valid <= 1'b0;
              r_uo_out    <= 8'd0;
              r_carry     <= 1'b0;
            end else begin
              r_cnt    <= w_cnt_inc;
              r_uo_out <= r_sum[w_cnt_inc];
            end
          end
        end

        default: begin
          r_cnt <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tt_um_sameerhegde_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_tt_um_sameerhegde_serial_adder
// Purpose  : Directed self-checking bench for the byte-serial adder with
//            NBYTES = 2. Expected sums are hand-computed constants.
// Revision : 1.0  initial release
// ============================================================================
module tb_tt_um_sameerhegde_serial_adder;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic       in_valid;
  logic       out_ready;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  logic in_ready;
  logic out_valid;
  logic carry;

  int tests;
  int failures;

  assign uio_in    = {6'b000000, out_ready, in_valid};
  assign in_ready  = uio_out[2];
  assign out_valid = uio_out[3];
  assign carry     = uio_out[4];

  tt_um_sameerhegde_serial_adder #(.NBYTES(2)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one byte and hold it until the DUT accepts it (bounded wait).
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    ui_in    = b;
    in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    check("in_ready_wait", {15'd0, in_ready}, 16'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_ops(input logic [15:0] a, input logic [15:0] b);
    send_byte(a[7:0]);
    send_byte(a[15:8]);
    send_byte(b[7:0]);
    send_byte(b[15:8]);
  endtask

  // Called one step after the edge that accepted the last B byte.
  task automatic expect_result(input logic [15:0] sum, input logic c, input int stall);
    check("lat_edge0_valid", {15'd0, out_valid}, 16'd0);
    tick();
    check("lat_edge1_valid", {15'd0, out_valid}, 16'd0);
    tick();
    check("rise_valid", {15'd0, out_valid}, 16'd1);
    check("rise_byte0", {8'd0, uo_out}, {8'd0, sum[7:0]});
    check("rise_carry", {15'd0, carry}, {15'd0, c});
    out_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1;
      ui_in    = 8'hFF;
      tick();
      check("stall_byte0", {8'd0, uo_out}, {8'd0, sum[7:0]});
      check("stall_valid", {15'd0, out_valid}, 16'd1);
      check("stall_carry", {15'd0, carry}, {15'd0, c});
      check("stall_in_ready", {15'd0, in_ready}, 16'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("byte1", {8'd0, uo_out}, {8'd0, sum[15:8]});
    check("byte1_valid", {15'd0, out_valid}, 16'd1);
    check("byte1_carry", {15'd0, carry}, {15'd0, c});
    tick();
    out_ready = 1'b0;
    check("drain_valid", {15'd0, out_valid}, 16'd0);
    check("drain_uo", {8'd0, uo_out}, 16'd0);
    check("drain_carry", {15'd0, carry}, 16'd0);
    check("drain_in_ready", {15'd0, in_ready}, 16'd1);
  endtask

  initial begin
    tests     = 0;
    failures  = 0;
    rst_n     = 1'b0;
    ena       = 1'b1;
    ui_in     = 8'h00;
    in_valid  = 1'b1;
    out_ready = 1'b0;

    // 1. Reset with in_valid held high
    tick();
    tick();
    check("rst_uo_out", {8'd0, uo_out}, 16'd0);
    check("rst_out_valid", {15'd0, out_valid}, 16'd0);
    check("rst_in_ready", {15'd0, in_ready}, 16'd0);
    check("rst_uio_oe", {8'd0, uio_oe}, 16'h001C);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    #1;
    check("rel_in_ready", {15'd0, in_ready}, 16'd1);

    // 2. Basic add, out_ready already high during the load and add phases
    out_ready = 1'b1;
    send_ops(16'h1234, 16'h0101);
    expect_result(16'h1335, 1'b0, 0);

    // 3. Overflow, then carry ripple between bytes
    send_ops(16'hFFFF, 16'h0001);
    expect_result(16'h0000, 1'b1, 0);
    send_ops(16'h00FF, 16'h0001);
    expect_result(16'h0100, 1'b0, 0);

    // 4. Backpressure on result 0xBEEF, in_valid asserted while not loading
    send_ops(16'hBEEE, 16'h0001);
    expect_result(16'hBEEF, 1'b0, 5);

    // 5. Gaps and ena drop during load of A=0xA5C3, B=0x1111
    ui_in = 8'hC3; in_valid = 1'b0; tick();
    in_valid = 1'b1; tick();                 // C3 accepted
    in_valid = 1'b0; ui_in = 8'hA5; tick();
    ena = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ena0_in_ready", {15'd0, in_ready}, 16'd1);
      check("ena0_out_valid", {15'd0, out_valid}, 16'd0);
    end
    ena = 1'b1; tick();                      // A5 accepted
    in_valid = 1'b0; ui_in = 8'h11; tick();
    tick();
    in_valid = 1'b1; tick();                 // 11 accepted
    in_valid = 1'b0; tick();
    in_valid = 1'b1; tick();                 // 11 accepted
    in_valid = 1'b0;
    expect_result(16'hB6D4, 1'b0, 0);

    // 6a. Reset in the middle of ADD
    send_ops(16'h4321, 16'h1111);
    rst_n = 1'b0;
    tick();
    check("radd_out_valid", {15'd0, out_valid}, 16'd0);
    check("radd_in_ready", {15'd0, in_ready}, 16'd0);
    rst_n = 1'b1;
    #1;
    check("radd_rel_in_ready", {15'd0, in_ready}, 16'd1);
    tick();
    tick();
    check("radd_no_result", {15'd0, out_valid}, 16'd0);

    // 6b. Reset in the middle of OUT, after the first byte left
    send_ops(16'hFFFF, 16'hFFFF);
    tick();
    tick();
    check("rout_valid_up", {15'd0, out_valid}, 16'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    check("rout_out_valid", {15'd0, out_valid}, 16'd0);
    check("rout_uo_out", {8'd0, uo_out}, 16'd0);
    check("rout_carry", {15'd0, carry}, 16'd0);
    rst_n = 1'b1;
    #1;
    check("rout_rel_in_ready", {15'd0, in_ready}, 16'd1);

    // Fresh add after the interrupted operations
    send_ops(16'h0002, 16'h0003);
    expect_result(16'h0005, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
`default_nettype wire
